// File: rtl/addsub_result_buf.sv
// Small FIFO that captures 4-bit adder-subtractor results with carry/borrow, overflow, zero and negative flags.
// Optional saturation of overflowing results is enabled by defining ADDSUB_SAT_EN.
module addsub_result_buf #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_m,
    input  logic [3:0] in_sum,
    input  logic       in_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_res,
    output logic       out_c,
    output logic       out_v,
    output logic       out_z,
    output logic       out_n,
    output logic [2:0] count,
    output logic [7:0] ovf_cnt
);

    localparam int         PW   = (DEPTH == 4) ? 2 : 1;
    localparam logic [2:0] FULL = 3'(DEPTH);

    // Entry layout: {res[3:0], c, v, z, n}
    logic [7:0]    mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [2:0]    count_reg;
    logic [7:0]    ovf_cnt_reg;

    logic       push;
    logic       pop;
    logic       c_next;
    logic       v_next;
    logic [3:0] res_next;
    logic [7:0] entry_next;
    logic [7:0] head;

    // Only the sign bits of the operands take part in the overflow test.
    logic unused_bits;
    assign unused_bits = ^{in_a[2:0], in_b[2:0]};

    assign in_ready  = (count_reg < FULL);
    assign out_valid = (count_reg != 3'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        c_next = in_cout ^ in_m;
        v_next = (in_a[3] == (in_b[3] ^ in_m)) && (in_sum[3] != in_a[3]);
`ifdef ADDSUB_SAT_EN
        if (v_next) begin
            res_next = in_a[3] ? 4'b1000 : 4'b0111;
        end else begin
            res_next = in_sum;
        end
`else
        res_next = in_sum;
`endif
        entry_next = {res_next, c_next, v_next, (res_next == 4'b0000), res_next[3]};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= entry_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= 3'd0;
            ovf_cnt_reg <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
            if (push && v_next && (ovf_cnt_reg != 8'hFF)) begin
                ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
            end
        end
    end

    // Stale storage is masked so an empty buffer presents all-zero outputs.
    assign head    = out_valid ? mem_reg[rd_ptr_reg] : 8'd0;
    assign out_res = head[7:4];
    assign out_c   = head[3];
    assign out_v   = head[2];
    assign out_z   = head[1];
    assign out_n   = head[0];
    assign count   = count_reg;
    assign ovf_cnt = ovf_cnt_reg;

endmodule

// File: tb/tb_addsub_result_buf.sv
// Directed self-checking bench for addsub_result_buf (DEPTH = 2); honours ADDSUB_SAT_EN for saturated expectations.
module tb_addsub_result_buf;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_m;
    logic [3:0] in_sum;
    logic       in_cout;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_res;
    logic       out_c;
    logic       out_v;
    logic       out_z;
    logic       out_n;
    logic [2:0] count;
    logic [7:0] ovf_cnt;

    int vectors = 0;
    int miscompares = 0;

    addsub_result_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_m(in_m), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n),
        .count(count), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic m, input logic [3:0] s, input logic co);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_m     = m;
        in_sum   = s;
        in_cout  = co;
    endtask

    initial begin
        logic [3:0] exp_res;
        logic [3:0] exp_flags;

        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        check("rst_count", 8'(count), 8'd0);
        check("rst_valid", 8'(out_valid), 8'd0);
        check("rst_ready", 8'(in_ready), 8'd1);
        check("rst_ovf", ovf_cnt, 8'd0);
        check("rst_res", 8'(out_res), 8'd0);

        // Subtract with borrow, negative result
        drive(1'b1, 4'b1000, 4'b1100, 1'b1, 4'b1100, 1'b0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("sub1_valid", 8'(out_valid), 8'd1);
        check("sub1_res", 8'(out_res), 8'b1100);
        check("sub1_cvzn", 8'({out_c, out_v, out_z, out_n}), 8'b1001);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop1_count", 8'(count), 8'd0);
        check("empty_res", 8'({out_res, out_c, out_v, out_z, out_n}), 8'd0);

        // Subtract giving zero
        drive(1'b1, 4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b1);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("sub2_res", 8'(out_res), 8'b0000);
        check("sub2_cvzn", 8'({out_c, out_v, out_z, out_n}), 8'b0010);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Subtract with signed overflow
        drive(1'b1, 4'b0111, 4'b1011, 1'b1, 4'b1100, 1'b0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
`ifdef ADDSUB_SAT_EN
        exp_res = 4'b0111;
        exp_flags = 4'b1100;
`else
        exp_res = 4'b1100;
        exp_flags = 4'b1101;
`endif
        check("ovf_res", 8'(out_res), 8'(exp_res));
        check("ovf_cvzn", 8'({out_c, out_v, out_z, out_n}), 8'(exp_flags));
        check("ovf_cnt1", ovf_cnt, 8'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Fill past capacity; the extra (overflowing) push must be dropped entirely
        for (int i = 0; i <= DEPTH; i++) begin
            if (i == DEPTH) drive(1'b1, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0);
            else            drive(1'b1, 4'd0, 4'd0, 1'b0, 4'(i + 1), 1'b0);
            tick();
            check("fill_count", 8'(count), 8'((i + 1 > DEPTH) ? DEPTH : i + 1));
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("full_ready", 8'(in_ready), 8'd0);
        check("drop_ovf", ovf_cnt, 8'd1);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_res", 8'(out_res), 8'(i + 1));
            tick();
            check("drain_count", 8'(count), 8'(DEPTH - 1 - i));
        end
        out_ready = 1'b0;

        // Simultaneous push and pop at count 1, then reset with entries held
        drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd5, 1'b0);
        tick();
        check("pp_pre_count", 8'(count), 8'd1);
        drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd6, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_count", 8'(count), 8'd1);
        check("pp_head", 8'(out_res), 8'd6);
        drive(1'b1, 4'd0, 4'd0, 1'b0, 4'd7, 1'b0);
        tick();
        check("pre_rst_count", 8'(count), 8'd2);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("rst2_count", 8'(count), 8'd0);
        check("rst2_valid", 8'(out_valid), 8'd0);
        check("rst2_ovf", ovf_cnt, 8'd0);
        check("rst2_res", 8'(out_res), 8'd0);

        // Overflow counter saturation
        out_ready = 1'b1;
        drive(1'b1, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 253) check("ovf_254", ovf_cnt, 8'd254);
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("ovf_sat", ovf_cnt, 8'd255);
        tick();
        check("ovf_hold", ovf_cnt, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
